// File: rtl/rgb_pattern_sequencer_pkg.sv
// rgb_pattern_sequencer_pkg: shared state encodings, widths and pattern-step helper
package rgb_pattern_sequencer_pkg;
  localparam int PAT_SEL_W = 4;
  localparam int DWELL_W = 16;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;
  function automatic logic [PAT_SEL_W-1:0] next_pat(input logic [PAT_SEL_W-1:0] sel,
                                                    input logic [PAT_SEL_W-1:0] last);
    return (sel == last) ? '0 : sel + 1'b1;
  endfunction
endpackage

// File: rtl/rgb_pattern_sequencer_vsa_edge_detect.sv
// vsa_edge_detect: registers VSA and flags its rising edge as the frame tick
module vsa_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsa,
  output logic o_tick
);
  logic r_vsa_d;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_vsa_d <= 1'b0;
    else r_vsa_d <= i_vsa;
  assign o_tick = i_vsa & ~r_vsa_d;
endmodule

// File: rtl/rgb_pattern_sequencer.sv
// rgb_pattern_sequencer: frame-aligned test pattern selection with dwell timer,
// manual req/ack advance and optional black frame between patterns
module rgb_pattern_sequencer
  import rgb_pattern_sequencer_pkg::*;
#(
  parameter int PAT_NUM      = 8,
  parameter int DWELL_FRAMES = 60,
  parameter int BLANK_EN     = 1
) (
  input  logic                 Sys_Clock,
  input  logic                 Reset,
  input  logic                 VSA,
  input  logic                 Auto_En,
  input  logic                 Hold,
  input  logic                 Next_Req,
  output logic                 Next_Ack,
  output logic [PAT_SEL_W-1:0] Pattern_Sel,
  output logic                 Blank,
  output logic                 Wrap_Pulse,
  output logic [15:0]          Frame_Cnt,
  output logic [1:0]           State
);
  localparam logic [PAT_SEL_W-1:0] LAST_PAT   = PAT_SEL_W'(PAT_NUM - 1);
  localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
  state_t                 r_state, w_state_nxt;
  logic [PAT_SEL_W-1:0]   r_sel;
  logic [DWELL_W-1:0]     r_dwell;
  logic [15:0]            r_fcnt;
  logic                   r_pend, r_ack, r_wrap;
  logic                   w_tick, w_show, w_blank, w_expire, w_adv, w_accept;
  vsa_edge_detect u_edge (
    .i_clk (Sys_Clock),
    .i_rst (Reset),
    .i_vsa (VSA),
    .o_tick(w_tick)
  );
  assign w_show   = (r_state == ST_SHOW);
  assign w_blank  = (r_state == ST_BLANK);
  assign w_expire = Auto_En & ~Hold & (r_dwell == DWELL_LAST);
  assign w_adv    = w_tick & ((w_show & (w_expire | r_pend)) | (w_blank & r_pend));
  assign w_accept = (w_show | w_blank) & Next_Req & ~r_pend & ~r_ack;
  always_ff @(posedge Sys_Clock or posedge Reset)
    if (Reset) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  // encoding 3 is unreachable but recovers like IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SHOW:  w_state_nxt = (w_adv && BLANK_EN != 0) ? ST_BLANK : ST_SHOW;
      ST_BLANK: w_state_nxt = (w_tick && !r_pend) ? ST_SHOW : ST_BLANK;
      default:  w_state_nxt = w_tick ? ST_SHOW : r_state;
    endcase
  end
  always_comb begin
    Blank       = ~w_show;
    State       = r_state;
    Next_Ack    = r_ack;
    Pattern_Sel = r_sel;
    Wrap_Pulse  = r_wrap;
    Frame_Cnt   = r_fcnt;
  end
  // a request accepted on an advancing edge survives it: set wins over clear
  always_ff @(posedge Sys_Clock or posedge Reset)
    if (Reset) begin
      r_sel   <= '0;
      r_dwell <= '0;
      r_fcnt  <= '0;
      r_pend  <= 1'b0;
      r_ack   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_ack  <= w_accept;
      r_wrap <= w_adv & (r_sel == LAST_PAT);
      if (w_tick) r_fcnt <= r_fcnt + 1'b1;
      if (w_adv) r_sel <= next_pat(r_sel, LAST_PAT);
      if (w_accept) r_pend <= 1'b1;
      else if (w_adv) r_pend <= 1'b0;
      if (w_adv || (w_tick && !w_show && !w_blank)) r_dwell <= '0;
      else if (w_tick && w_show && Auto_En && !Hold) r_dwell <= r_dwell + 1'b1;
    end
endmodule

// File: tb/tb_rgb_pattern_sequencer.sv
// tb_rgb_pattern_sequencer: directed plus randomized checks of two configurations
// (black frame on / off) against a frame-level behavioural model
module tb_rgb_pattern_sequencer;
  localparam int PAT = 4;
  localparam int DWELL = 3;
  logic clk = 1'b0, rst = 1'b0, vsa = 1'b0, auto_en = 1'b0, hold = 1'b0, req = 1'b0, rnd = 1'b0;
  logic ack0, blank0, wrap0, ack1, blank1, wrap1;
  logic [3:0] sel0, sel1;
  logic [15:0] fcnt0, fcnt1;
  logic [1:0] st0, st1;
  int checks = 0, errors = 0, wraps0 = 0;
  bit m_vsad;
  bit m_run[2], m_blk[2], m_pend[2], m_ack[2], m_wrap[2];
  int m_sel[2], m_dwell[2], m_fcnt[2];

  rgb_pattern_sequencer #(.PAT_NUM(PAT), .DWELL_FRAMES(DWELL), .BLANK_EN(1)) dut0 (
    .Sys_Clock(clk), .Reset(rst), .VSA(vsa), .Auto_En(auto_en), .Hold(hold), .Next_Req(req),
    .Next_Ack(ack0), .Pattern_Sel(sel0), .Blank(blank0), .Wrap_Pulse(wrap0), .Frame_Cnt(fcnt0),
    .State(st0));
  rgb_pattern_sequencer #(.PAT_NUM(PAT), .DWELL_FRAMES(DWELL), .BLANK_EN(0)) dut1 (
    .Sys_Clock(clk), .Reset(rst), .VSA(vsa), .Auto_En(auto_en), .Hold(hold), .Next_Req(req),
    .Next_Ack(ack1), .Pattern_Sel(sel1), .Blank(blank1), .Wrap_Pulse(wrap1), .Frame_Cnt(fcnt1),
    .State(st1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vsad = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_blk[k] = 0; m_pend[k] = 0; m_ack[k] = 0; m_wrap[k] = 0;
      m_sel[k] = 0; m_dwell[k] = 0; m_fcnt[k] = 0;
    end
  endtask

  // m_run: a frame has started since reset; m_blk: current frame is a black frame
  task automatic model_step();
    bit tick, adv, acc;
    tick = vsa && !m_vsad;
    m_vsad = vsa;
    for (int k = 0; k < 2; k++) begin
      acc = m_run[k] && req && !m_pend[k] && !m_ack[k];
      adv = 0;
      m_wrap[k] = 0;
      if (tick) begin
        m_fcnt[k] = (m_fcnt[k] + 1) % 65536;
        if (!m_run[k]) begin
          m_run[k] = 1; m_blk[k] = 0; m_dwell[k] = 0;
        end else if (m_blk[k]) begin
          if (m_pend[k]) adv = 1; else m_blk[k] = 0;
        end else if ((auto_en && !hold && m_dwell[k] == DWELL - 1) || m_pend[k]) adv = 1;
        else if (auto_en && !hold) m_dwell[k]++;
      end
      if (adv) begin
        m_wrap[k] = (m_sel[k] == PAT - 1);
        m_sel[k] = (m_sel[k] + 1) % PAT;
        m_dwell[k] = 0;
        m_pend[k] = 0;
        if (k == 0) m_blk[k] = 1;
      end
      if (acc) m_pend[k] = 1;
      m_ack[k] = acc;
    end
  endtask

  task automatic cmp(input int k, input logic a, input logic [3:0] s, input logic b, input logic w,
                     input logic [15:0] f, input logic [1:0] st);
    chk($sformatf("i%0d.ack", k), a, m_ack[k]);
    chk($sformatf("i%0d.sel", k), s, m_sel[k]);
    chk($sformatf("i%0d.blank", k), b, !m_run[k] || m_blk[k]);
    chk($sformatf("i%0d.wrap", k), w, m_wrap[k]);
    chk($sformatf("i%0d.fcnt", k), f, m_fcnt[k]);
    chk($sformatf("i%0d.state", k), st, !m_run[k] ? 0 : (m_blk[k] ? 2 : 1));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    cmp(0, ack0, sel0, blank0, wrap0, fcnt0, st0);
    cmp(1, ack1, sel1, blank1, wrap1, fcnt1, st1);
    if (wrap0) wraps0++;
    if (rnd) begin
      auto_en = $urandom_range(0, 3) != 0;
      hold = $urandom_range(0, 5) == 0;
      req = $urandom_range(0, 3) == 0;
    end
  endtask

  task automatic frame(input int len);
    vsa = 1'b1;
    cycle();
    cycle();
    vsa = 1'b0;
    repeat (len - 2) cycle();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (3) cycle();
    req = 1'b1;
    repeat (3) cycle();
    req = 1'b0;
    frame(8);
    chk("first.fcnt", fcnt0, 16'd1);
    chk("first.sel", sel0, 4'd0);
    chk("first.blank", blank0, 1'b0);
    auto_en = 1'b1;
    wraps0 = 0;
    repeat (16) frame(6);
    chk("auto.wraps", wraps0, 1);
    chk("auto.sel", sel0, 4'd0);
    chk("auto.blank", blank0, 1'b0);
    hold = 1'b1;
    repeat (5) frame(5);
    hold = 1'b0;
    repeat (4) frame(5);
    auto_en = 1'b0;
    frame(6);
    vsa = 1'b1;
    cycle();
    cycle();
    vsa = 1'b0;
    cycle();
    req = 1'b1;
    repeat (5) cycle();
    frame(8);
    req = 1'b0;
    repeat (3) frame(7);
    rnd = 1'b1;
    repeat (30) frame($urandom_range(4, 10));
    rnd = 1'b0;
    req = 1'b0;
    auto_en = 1'b1;
    hold = 1'b0;
    repeat (5) frame(5);
    #3 rst = 1'b1;
    #1 model_reset();
    chk("arst.sel", sel0, 4'd0);
    chk("arst.blank", blank0, 1'b1);
    chk("arst.fcnt", fcnt0, 16'd0);
    chk("arst.state", st0, 2'd0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    frame(6);
    chk("restart.state", st0, 2'd1);
    chk("restart.sel", sel0, 4'd0);
    chk("restart.fcnt", fcnt0, 16'd1);
    repeat (4) frame(6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
